fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and F/D pipeline latch of the five-stage processor. It holds the program counter, drives the instruction-memory address, and registers the fetched word into the F/D latch whose `fd_instruction` output feeds the decode controller's `instruction_in`. It honours hazard stalls and execute-stage redirects (branch/jump/jr). Optionally, it predecodes unconditional `j`/`jal` so they redirect at fetch instead of execute.

## Interface
Parameters:
- `PC_W`, 12: program counter / instruction-memory address width in words.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `stall` in 1: hazard unit hold request; freezes PC and F/D latch.
- `redirect` in 1: execute-stage taken branch/jump/jr.
- `redirect_target` in PC_W: new PC when `redirect`=1.
- `imem_addr` out PC_W: instruction-memory word address, equal to the current PC. Read is combinational.
- `imem_data` in 32: instruction word at `imem_addr`, same cycle.
- `fd_instruction` out 32: latched instruction to decode; 32'h0 is a nop.
- `fd_pc_plus1` out PC_W: latched PC+1 of that instruction, used for link and branch base.
- `fd_valid` out 1: 1 when `fd_instruction` is a real fetched word, 0 for a bubble.
- `fd_predicted` out 1: 1 when the latched `j`/`jal` was already redirected at fetch.
- `fetch_count` out 32: number of valid instructions latched into F/D since reset.

## Operation
- Reset values:
  - `pc` = 0.
  - `fd_instruction` = 0, `fd_pc_plus1` = 0.
  - `fd_valid` = 0, `fd_predicted` = 0.
  - `fetch_count` = 0.
- Next-PC selection per edge, highest priority first:
  1. `redirect`=1 → `pc` <= `redirect_target`.
  2. `stall`=1 → `pc` holds.
  3. Predecode hit (see Configuration) → `pc` <= `imem_data[PC_W-1:0]`.
  4. Otherwise `pc` <= `pc`+1, mod 2^PC_W. At all-ones the PC wraps to 0.
- F/D latch update per edge:
  - `redirect`=1 → latch bubble: instruction 0, `fd_valid`=0, `fd_predicted`=0, `fd_pc_plus1`=0. This applies even when `stall`=1.
  - else `stall`=1 → all F/D outputs hold.
  - else latch `imem_data`, `pc`+1, `fd_valid`=1, and `fd_predicted` = predecode hit.
- `fetch_count` increments by 1 (wrapping at 2^32) on every edge where `fd_valid` is written as 1.
- Target truncation: jump targets and `redirect_target` use only the low PC_W bits.
- Reset asserted mid-operation clears all state immediately, regardless of clock. The first edge after deassertion fetches address 0.

## Timing
- Fetch latency: the word at PC p appears on `fd_instruction` 1 cycle after `imem_addr`=p, at the next unstalled edge.
- Redirect penalty:
  - `redirect` sampled at edge n → `imem_addr` = target during cycle n+1.
  - `fd_instruction` is a bubble during cycle n+1.
  - The target instruction is latched at edge n+1.
- `stall` held for k cycles → PC and F/D outputs are unchanged for exactly k edges, and `fetch_count` does not advance.
- Predecode hit at edge n → `imem_addr` = jump target in cycle n+1, with no bubble.

## Configuration
- `FETCH_JUMP_PREDECODE_EN` defined:
  - A predecode hit is `imem_data[31:27]` equal to 5'b00001 (`j`) or 5'b00011 (`jal`).
  - On a hit, the next PC is `imem_data[PC_W-1:0]` and `fd_predicted` is latched as 1.
  - The execute stage suppresses its own redirect for instructions with `fd_predicted`=1.
  - `jal` is still passed down so that r31 gets written.
- Not defined:
  - No predecode; `j`/`jal` redirect only via `redirect`.
  - `fd_predicted` is a constant 0.

## Test plan
- Reset then 4 free-running cycles with imem[i] = i+100:
  - `fd_instruction` = 100, 101, 102, 103.
  - `fd_pc_plus1` = 1, 2, 3, 4.
  - `fetch_count` = 4.
- `stall` high for 3 cycles at pc=5:
  - `imem_addr` stays 5 and `fd_*` hold for 3 edges.
  - Fetch resumes at 5, then 6.
- `redirect`=1, target=40, at pc=9:
  - Next cycle `imem_addr`=40 and `fd_valid`=0.
  - The following edge latches imem[40] with `fd_pc_plus1`=41.
- `redirect` and `stall` both high: redirect wins, `pc`=target, and a bubble is latched.
- PC_W=12, pc=4095: next `imem_addr`=0, and `fd_pc_plus1` of that word = 0.
- With `FETCH_JUMP_PREDECODE_EN`, imem[3] = `j` to 20 (32'h08000014):
  - Cycle after latching it: `imem_addr`=20 and `fd_predicted`=1.
  - No bubble.
- Without `FETCH_JUMP_PREDECODE_EN`: `imem_addr`=4 follows, and `fd_predicted`=0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and F/D pipeline latch.
// Holds the PC, drives the combinational instruction-memory address and
// registers the fetched word for decode. Execute-stage redirects have
// priority over hazard stalls.
// Optional feature macro: FETCH_JUMP_PREDECODE_EN. When it is defined,
// unconditional j/jal are recognised at fetch and redirect the PC without
// a bubble. The default build has no predecode and fd_predicted stays 0.
module fetch_stage #(
    parameter int PC_W = 12
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    output logic [31:0]     fd_instruction,
    output logic [PC_W-1:0] fd_pc_plus1,
    output logic            fd_valid,
    output logic            fd_predicted,
    output logic [31:0]     fetch_count
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus1;
    logic [31:0]     fd_instr_q;
    logic [PC_W-1:0] fd_pc_plus1_q;
    logic            fd_valid_q;
    logic            fd_pred_q;
    logic [31:0]     fetch_count_q;
    logic            predecode_hit;
    logic            fd_load;

    // Wraps naturally at all-ones because the sum is truncated to PC_W bits.
    assign pc_plus1 = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

`ifdef FETCH_JUMP_PREDECODE_EN
    assign predecode_hit = (imem_data[31:27] == 5'b00001) ||
                           (imem_data[31:27] == 5'b00011);
`else
    assign predecode_hit = 1'b0;
`endif

    // A real word enters F/D only on an edge that is neither redirected nor stalled.
    assign fd_load = !redirect && !stall;

    // Next-PC selection: redirect, then stall, then predecoded jump, then sequential.
    always_comb begin
        pc_d = pc_plus1;
        if (redirect) begin
            pc_d = redirect_target;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (predecode_hit) begin
            pc_d = imem_data[PC_W-1:0];
        end
    end

    // PC register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // F/D latch: a redirect flushes it even while stalled; a stall alone holds it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fd_instr_q    <= 32'h0;
            fd_pc_plus1_q <= '0;
            fd_valid_q    <= 1'b0;
            fd_pred_q     <= 1'b0;
        end else if (redirect) begin
            fd_instr_q    <= 32'h0;
            fd_pc_plus1_q <= '0;
            fd_valid_q    <= 1'b0;
            fd_pred_q     <= 1'b0;
        end else if (!stall) begin
            fd_instr_q    <= imem_data;
            fd_pc_plus1_q <= pc_plus1;
            fd_valid_q    <= 1'b1;
            fd_pred_q     <= predecode_hit;
        end
    end

    // Count of valid words written into F/D; wraps at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count_q <= 32'h0;
        end else if (fd_load) begin
            fetch_count_q <= fetch_count_q + 32'h1;
        end
    end

    assign imem_addr      = pc_q;
    assign fd_instruction = fd_instr_q;
    assign fd_pc_plus1    = fd_pc_plus1_q;
    assign fd_valid       = fd_valid_q;
    assign fd_predicted   = fd_pred_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios with literal expectations,
// then randomized stall/redirect/memory traffic checked every cycle against
// a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int PC_W  = 12;
    localparam int DEPTH = 1 << PC_W;
`ifdef FETCH_JUMP_PREDECODE_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            stall = 1'b0;
    logic            redirect = 1'b0;
    logic [PC_W-1:0] redirect_target = '0;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic [31:0]     fd_instruction;
    logic [PC_W-1:0] fd_pc_plus1;
    logic            fd_valid;
    logic            fd_predicted;
    logic [31:0]     fetch_count;

    logic [31:0] mem [0:DEPTH-1];

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int          m_pc;
    logic [31:0] m_ins;
    int          m_pcp1;
    bit          m_valid;
    bit          m_pred;
    longint      m_cnt;

    fetch_stage #(.PC_W(PC_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .fd_instruction  (fd_instruction),
        .fd_pc_plus1     (fd_pc_plus1),
        .fd_valid        (fd_valid),
        .fd_predicted    (fd_predicted),
        .fetch_count     (fetch_count)
    );

    assign imem_data = mem[imem_addr];

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ins = 0; m_pcp1 = 0; m_valid = 0; m_pred = 0; m_cnt = 0;
    endtask

    // One clock edge of the fetch rules, written from the architectural description.
    task automatic model_edge(input bit st, input bit rd, input int tgt);
        logic [31:0] w;
        bit          jmp;
        w   = mem[m_pc];
        jmp = PRED && (w[31:27] == 5'b00001 || w[31:27] == 5'b00011);
        if (rd) begin
            m_ins = 0; m_pcp1 = 0; m_valid = 0; m_pred = 0;
            m_pc  = tgt % DEPTH;
        end else if (!st) begin
            m_ins   = w;
            m_pcp1  = (m_pc + 1) % DEPTH;
            m_valid = 1;
            m_pred  = jmp;
            m_cnt   = (m_cnt + 1) % (64'd1 << 32);
            m_pc    = jmp ? int'(w) % DEPTH : (m_pc + 1) % DEPTH;
        end
    endtask

    // Called at a falling edge: apply inputs, take the rising edge, return at the next falling edge.
    task automatic step(input bit st, input bit rd, input int tgt);
        stall = st;
        redirect = rd;
        redirect_target = PC_W'(tgt);
        @(posedge clock);
        model_edge(st, rd, tgt);
        @(negedge clock);
    endtask

    // Single compare process: DUT against the model on every out-of-reset cycle.
    always @(negedge clock) begin
        if (!reset) begin
            chk("imem_addr",      32'(imem_addr),      32'(m_pc));
            chk("fd_instruction", fd_instruction,      m_ins);
            chk("fd_pc_plus1",    32'(fd_pc_plus1),    32'(m_pcp1));
            chk("fd_valid",       32'(fd_valid),       32'(m_valid));
            chk("fd_predicted",   32'(fd_predicted),   32'(m_pred));
            chk("fetch_count",    fetch_count,         32'(m_cnt));
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i + 100);
        model_reset();
        reset = 1'b1;
        #12;
        chk("rst imem_addr", 32'(imem_addr), 32'h0);
        chk("rst fd_instruction", fd_instruction, 32'h0);
        chk("rst fd_pc_plus1", 32'(fd_pc_plus1), 32'h0);
        chk("rst fd_valid", 32'(fd_valid), 32'h0);
        chk("rst fd_predicted", 32'(fd_predicted), 32'h0);
        chk("rst fetch_count", fetch_count, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Free-running fetch
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0);
            chk("seq fd_instruction", fd_instruction, 32'(100 + i));
            chk("seq fd_pc_plus1", 32'(fd_pc_plus1), 32'(i + 1));
        end
        chk("seq fetch_count", fetch_count, 32'd4);

        // Stall three cycles at pc=5
        step(0, 0, 0);
        chk("pre-stall imem_addr", 32'(imem_addr), 32'd5);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            chk("stall imem_addr", 32'(imem_addr), 32'd5);
            chk("stall fd_instruction", fd_instruction, 32'd104);
            chk("stall fetch_count", fetch_count, 32'd5);
        end
        step(0, 0, 0);
        chk("resume fd_instruction", fd_instruction, 32'd105);
        step(0, 0, 0);
        chk("resume2 fd_instruction", fd_instruction, 32'd106);

        // Redirect to 40 at pc=9
        step(0, 0, 0);
        step(0, 0, 0);
        chk("pre-redir imem_addr", 32'(imem_addr), 32'd9);
        step(0, 1, 40);
        chk("redir imem_addr", 32'(imem_addr), 32'd40);
        chk("redir fd_valid", 32'(fd_valid), 32'd0);
        step(0, 0, 0);
        chk("redir target word", fd_instruction, 32'd140);
        chk("redir fd_pc_plus1", 32'(fd_pc_plus1), 32'd41);

        // Redirect beats stall
        step(1, 1, 77);
        chk("redir+stall imem_addr", 32'(imem_addr), 32'd77);
        chk("redir+stall fd_valid", 32'(fd_valid), 32'd0);
        chk("redir+stall fd_instruction", fd_instruction, 32'd0);

        // PC wrap at all-ones
        step(0, 1, 4095);
        step(0, 0, 0);
        chk("wrap imem_addr", 32'(imem_addr), 32'd0);
        chk("wrap fd_pc_plus1", 32'(fd_pc_plus1), 32'd0);
        chk("wrap fd_instruction", fd_instruction, 32'd4195);

        // j to 20 at address 3
        mem[3] = 32'h0800_0014;
        step(0, 1, 3);
        step(0, 0, 0);
        chk("j imem_addr", 32'(imem_addr), PRED ? 32'd20 : 32'd4);
        chk("j fd_predicted", 32'(fd_predicted), 32'(PRED));
        chk("j fd_valid", 32'(fd_valid), 32'd1);
        step(0, 0, 0);
        chk("j next word", fd_instruction, PRED ? 32'd120 : 32'd104);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        chk("async rst imem_addr", 32'(imem_addr), 32'h0);
        chk("async rst fd_valid", 32'(fd_valid), 32'h0);
        chk("async rst fetch_count", fetch_count, 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        step(0, 0, 0);
        chk("post-rst first word", fd_instruction, mem[0]);
        chk("post-rst fd_pc_plus1", 32'(fd_pc_plus1), 32'd1);

        // Randomized traffic; some words are j/jal with garbage above the target field
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 5) == 0)
                w[31:27] = ($urandom_range(0, 1) == 0) ? 5'b00001 : 5'b00011;
            mem[i] = w;
        end
        for (int n = 0; n < 3000; n++) begin
            bit st, rd;
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 7) == 0);
            step(st, rd, int'($urandom_range(0, DEPTH - 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
